uart_rx_buffer: RTL
===================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: i_clk frequency in Hz.
REQ-002 Parameter DATA_W, default 8, legal 7 or 8: data bits per frame.
REQ-003 Parameter DEPTH, default 8, power of two from 2 to 256: FIFO entries.
REQ-004 Parameter PARITY_EN, default 0: 1 means one parity bit follows the data bits.
REQ-005 Parameter IDLE_CYCLES, default 46_080_000: quiet cycles before o_used drops.
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst  in  1  asynchronous, active-low reset.
REQ-008 i_baud  in  3  baud select: 0..7 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200.
REQ-009 i_rx  in  1  serial line, idle high, asynchronous to i_clk.
REQ-010 i_parity_odd  in  1  1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-011 i_read  in  1  pop strobe, one entry per cycle while high.
REQ-012 i_clr_err  in  1  clears all sticky error flags.
REQ-013 o_D  out  DATA_W  FIFO head, first-word fall-through.
REQ-014 o_ready  out  1  FIFO not empty.
REQ-015 o_level  out  clog2(DEPTH)+1  current entry count.
REQ-016 o_full  out  1  level equals DEPTH.
REQ-017 o_overflow, o_frame_err, o_parity_err  out  1 each  sticky error flags.
REQ-018 o_used  out  1  line activity indicator.

Function
REQ-019 i_rx SHALL pass through a 2-flop synchroniser before any use; this adds 2 cycles of input latency.
REQ-020 Bit period SHALL be DIV = CLK_HZ / baud(i_baud), using integer division; i_baud SHALL be sampled only in the IDLE state.
REQ-021 Deserialiser FSM SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-022 FSM transitions:
  - IDLE->START on a synchronised falling edge.
  - START->IDLE if the line is high at DIV/2 (glitch reject); otherwise START->DATA.
  - Data bits SHALL be sampled every DIV cycles, LSB first.
  - DATA->PARITY when PARITY_EN=1, otherwise DATA->STOP.
  - STOP->IDLE after the stop-bit sample.
REQ-023 A low stop bit SHALL set o_frame_err and discard the frame.
REQ-024 A parity mismatch SHALL set o_parity_err and discard the frame.
REQ-025 A good frame SHALL be pushed on the cycle after the stop-bit sample; it SHALL be visible on o_D/o_ready one cycle later if the FIFO was empty.
REQ-026 A push while full and without i_read SHALL drop the frame, set o_overflow, and leave FIFO contents unchanged.
REQ-027 A push and pop in the same cycle SHALL both take effect at any level, including full; o_level is unchanged.
REQ-028 i_read while empty SHALL be ignored: pointers and o_level unchanged, no error.
REQ-029 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; o_level SHALL be maintained as a separate counter.
REQ-030 i_clr_err SHALL clear all sticky flags; if an error event coincides with i_clr_err, the flag SHALL be set.
REQ-031 Activity FSM:
  - States UNUSED and USED.
  - UNUSED->USED when the deserialiser leaves IDLE.
  - In USED, an idle counter SHALL reset to 0 while the deserialiser is not IDLE, and increment otherwise.
  - USED->UNUSED when the counter reaches IDLE_CYCLES-1; the counter returns to 0.
  - o_used = (state == USED).

Reset
REQ-032 Asserting i_rst low SHALL immediately force:
  - deserialiser to IDLE, synchroniser to 1;
  - pointers, o_level and idle counter to 0;
  - activity state to UNUSED;
  - o_ready=0, o_full=0, all error flags 0, o_used=0, o_D=0 (storage cleared).
REQ-033 A frame in progress at reset SHALL be discarded; after release, reception SHALL resume at the next falling edge.

Structure
REQ-034 Package uart_pkg SHALL hold:
  - the baud-rate table;
  - the deserialiser and activity state enums;
  - a DIV function of (CLK_HZ, i_baud).
REQ-035 The deserialiser SHALL be the sub-module uart_rx_frame, with outputs data, valid, frame_err, parity_err and busy.
REQ-036 FIFO, error flags and activity FSM SHALL live in uart_rx_buffer.

Verification (CLK_HZ=1_152_000, i_baud=7, DIV=10, DEPTH=4, IDLE_CYCLES=50 unless stated)
REQ-037 Send 0xA5 with no parity -> o_ready rises, o_D=0xA5, o_level=1; one i_read -> o_ready=0, o_level=0.
REQ-038 Send 5 bytes 0x01..0x05 with no reads -> o_full=1, o_level=4, o_overflow=1, FIFO holds 0x01..0x04; then i_clr_err -> o_overflow=0.
REQ-039 Fill the FIFO with 0x10..0x13, then hold i_read high for exactly the push cycle of 0x14 -> o_level stays 4, o_overflow=0, read order 0x11..0x14.
REQ-040 With PARITY_EN=1 and i_parity_odd=1: send 0x03 with parity 1 -> accepted; send 0x03 with parity 0 -> o_parity_err=1, no push. Send 0x55 with a low stop bit -> o_frame_err=1, no push.
REQ-041 A 3-cycle low glitch -> no frame, o_used goes 1 then returns to 0 after 50 quiet cycles. Assert i_rst mid-frame -> all outputs 0 immediately, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encodings and baud-rate helpers for the UART receive buffer.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    ACT_UNUSED,
    ACT_USED
  } act_state_e;

  localparam int unsigned BAUD_TABLE [8] = '{
    1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Clock cycles per bit for the selected baud rate.
  function automatic logic [31:0] div_of(input int unsigned clk_hz, input logic [2:0] sel);
    return 32'(clk_hz / BAUD_TABLE[sel]);
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// Serial deserialiser: synchronises i_rx, validates the start bit and
// shifts in one frame, reporting it with a single-cycle valid or error pulse.
module uart_rx_frame #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_baud,
  input  logic              i_rx,
  input  logic              i_parity_odd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  import uart_pkg::*;

  rx_state_e         state_q;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [31:0]       div_q, cnt_q;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_bad_q;
  logic              bit_end;

  assign bit_end = (cnt_q == div_q - 32'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_bad_q  <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_s1_q    <= i_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt_q      <= cnt_q + 32'd1;
      case (state_q)
        RX_IDLE: begin
          // Baud select is latched here so a mid-frame change cannot skew timing.
          div_q <= div_of(CLK_HZ, i_baud);
          cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= RX_START;
            busy    <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt_q == (div_q >> 1)) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            par_bad_q <= 1'b0;
            if (rx_s2_q) begin
              state_q <= RX_IDLE;
              busy    <= 1'b0;
            end else begin
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            sh_q  <= {rx_s2_q, sh_q[DATA_W-1:1]};
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'(DATA_W - 1)) begin
              if (PARITY_EN) state_q <= RX_PARITY;
              else           state_q <= RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (bit_end) begin
            cnt_q     <= '0;
            par_bad_q <= ((^sh_q) ^ rx_s2_q) != i_parity_odd;
            state_q   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            state_q    <= RX_IDLE;
            busy       <= 1'b0;
            data       <= sh_q;
            frame_err  <= !rx_s2_q;
            parity_err <= par_bad_q;
            valid      <= rx_s2_q && !par_bad_q;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver with first-word fall-through FIFO, sticky error flags and
// a line-activity indicator that times out after a quiet period.
module uart_rx_buffer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 8,
  parameter bit          PARITY_EN   = 1'b0,
  parameter int unsigned IDLE_CYCLES = 46_080_000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [2:0]               i_baud,
  input  logic                     i_rx,
  input  logic                     i_parity_odd,
  input  logic                     i_read,
  input  logic                     i_clr_err,
  output logic [DATA_W-1:0]        o_D,
  output logic                     o_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_frame_err,
  output logic                     o_parity_err,
  output logic                     o_used
);
  import uart_pkg::*;

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] frm_data;
  logic              frm_valid, frm_ferr, frm_perr, frm_busy;

  uart_rx_frame #(
    .CLK_HZ   (CLK_HZ),
    .DATA_W   (DATA_W),
    .PARITY_EN(PARITY_EN)
  ) u_frame (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud      (i_baud),
    .i_rx        (i_rx),
    .i_parity_odd(i_parity_odd),
    .data        (frm_data),
    .valid       (frm_valid),
    .frame_err   (frm_ferr),
    .parity_err  (frm_perr),
    .busy        (frm_busy)
  );

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [AW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                  level_q, level_d;
  logic                         ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                         full, empty, push, pop;

  always_comb begin
    full  = (level_q == LVL_FULL);
    empty = (level_q == '0);
    pop   = i_read && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    push  = frm_valid && (!full || pop);

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = frm_data;
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

    // Set wins over clear when both land in the same cycle.
    ovf_d  = (ovf_q  && !i_clr_err) || (frm_valid && full && !i_read);
    ferr_d = (ferr_q && !i_clr_err) || frm_ferr;
    perr_d = (perr_q && !i_clr_err) || frm_perr;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  act_state_e  act_q;
  logic [31:0] idle_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      act_q  <= ACT_UNUSED;
      idle_q <= '0;
    end else begin
      case (act_q)
        ACT_UNUSED: begin
          if (frm_busy) begin
            act_q  <= ACT_USED;
            idle_q <= '0;
          end
        end
        ACT_USED: begin
          if (frm_busy) begin
            idle_q <= '0;
          end else if (idle_q == 32'(IDLE_CYCLES - 1)) begin
            act_q  <= ACT_UNUSED;
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + 32'd1;
          end
        end
        default: act_q <= ACT_UNUSED;
      endcase
    end
  end

  assign o_D          = mem_q[rptr_q];
  assign o_ready      = !empty;
  assign o_level      = level_q;
  assign o_full       = full;
  assign o_overflow   = ovf_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_used       = (act_q == ACT_USED);

endmodule
